// File: rtl/blitter_pkg.sv
// Shared blitter definitions: address/coordinate widths, engine states and the
// fill-command record used by the rectangle engine and the command decoder.
package blitter_pkg;

   localparam int ADDR_W  = 26;
   localparam int COORD_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      ROW   = 2'd2
   } blit_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  base;
      logic [COORD_W-1:0] stride;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
      logic [COORD_W-1:0] x2;
      logic [COORD_W-1:0] y2;
      logic [7:0]         colour;
   } fill_cmd_t;

   function automatic logic [31:0] replicate_colour(input logic [7:0] colour);
      return {4{colour}};
   endfunction

endpackage

// File: rtl/blitter_byte_mask.sv
// Per-word byte-enable generator for an 8-bit-pixel span: trims the leading
// bytes of a span's first word and the trailing bytes of its last word.
module blitter_byte_mask (
   input  logic [1:0] s_i,
   input  logic [1:0] e_i,
   input  logic       is_first_i,
   input  logic       is_last_i,
   output logic [3:0] byte_en_o
);

   logic [3:0] first_mask_s;
   logic [3:0] last_mask_s;

   assign first_mask_s = 4'b1111 << s_i;
   assign last_mask_s  = 4'b1111 >> (2'd3 - e_i);

   // Choose the mask by the word's position inside the span.
   always_comb begin
      byte_en_o = 4'b1111;
      case ({is_first_i, is_last_i})
         2'b11:   byte_en_o = first_mask_s & last_mask_s;
         2'b10:   byte_en_o = first_mask_s;
         2'b01:   byte_en_o = last_mask_s;
         default: byte_en_o = 4'b1111;
      endcase
   end

endmodule

// File: rtl/blitter_rect_fill.sv
// Rectangle-fill engine: walks an inclusive rectangle row by row and streams
// word-aligned 32-bit writes with byte enables into the blitter write FIFO.
module blitter_rect_fill #(
   parameter int ADDR_W  = blitter_pkg::ADDR_W,
   parameter int COORD_W = blitter_pkg::COORD_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ADDR_W-1:0]  cmd_base,
   input  logic [COORD_W-1:0] cmd_stride,
   input  logic [COORD_W-1:0] cmd_x1,
   input  logic [COORD_W-1:0] cmd_y1,
   input  logic [COORD_W-1:0] cmd_x2,
   input  logic [COORD_W-1:0] cmd_y2,
   input  logic [7:0]         cmd_colour,
   output logic [ADDR_W-1:0]  out_address,
   output logic [3:0]         out_byte_en,
   output logic [31:0]        out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               done
);

   import blitter_pkg::*;

   localparam int PAD_W = ADDR_W - COORD_W;

   blit_state_e        state_q, state_d;
   fill_cmd_t          cmd_q, cmd_d;
   logic [ADDR_W-1:0]  row_addr_q, row_addr_d;
   logic [COORD_W-1:0] row_q, row_d;
   logic [ADDR_W-1:0]  nxt_q, nxt_d;
   logic               first_q, first_d;
   logic               gen_done_q, gen_done_d;
   logic               out_valid_q, out_valid_d;
   logic [ADDR_W-1:0]  out_address_q, out_address_d;
   logic [3:0]         out_byte_en_q, out_byte_en_d;
   logic [31:0]        out_data_q, out_data_d;
   logic               done_q, done_d;

   logic [ADDR_W-1:0]  stride_ext_s;
   logic [ADDR_W-1:0]  y1_ext_s;
   logic [ADDR_W-1:0]  row_off_s;
   logic [ADDR_W-1:0]  s_s;
   logic [ADDR_W-1:0]  e_s;
   logic [ADDR_W-1:0]  word_addr_s;
   logic [ADDR_W-1:0]  last_addr_s;
   logic               is_last_s;
   logic               advance_s;
   logic [3:0]         mask_s;

   assign stride_ext_s = {{PAD_W{1'b0}}, cmd_q.stride};
   assign y1_ext_s     = {{PAD_W{1'b0}}, cmd_q.y1};
   // Operands are widened to ADDR_W so the product truncates naturally mod 2^ADDR_W.
   assign row_off_s    = y1_ext_s * stride_ext_s;

   assign s_s         = row_addr_q + {{PAD_W{1'b0}}, cmd_q.x1};
   assign e_s         = row_addr_q + {{PAD_W{1'b0}}, cmd_q.x2};
   assign last_addr_s = {e_s[ADDR_W-1:2], 2'b00};
   assign word_addr_s = first_q ? {s_s[ADDR_W-1:2], 2'b00} : nxt_q;
   assign is_last_s   = (word_addr_s == last_addr_s);
   // The output slot refills whenever it is empty or its word is being accepted.
   assign advance_s   = (state_q == ROW) && !gen_done_q && (!out_valid_q || out_ready);

   blitter_byte_mask u_byte_mask (
      .s_i        (s_s[1:0]),
      .e_i        (e_s[1:0]),
      .is_first_i (first_q),
      .is_last_i  (is_last_s),
      .byte_en_o  (mask_s)
   );

   // Next-state and datapath update for command intake, setup and row walking.
   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      row_addr_d    = row_addr_q;
      row_d         = row_q;
      nxt_d         = nxt_q;
      first_d       = first_q;
      gen_done_d    = gen_done_q;
      out_valid_d   = out_valid_q;
      out_address_d = out_address_q;
      out_byte_en_d = out_byte_en_q;
      out_data_d    = out_data_q;
      done_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               cmd_d.base   = cmd_base;
               cmd_d.stride = cmd_stride;
               cmd_d.x1     = cmd_x1;
               cmd_d.y1     = cmd_y1;
               cmd_d.x2     = cmd_x2;
               cmd_d.y2     = cmd_y2;
               cmd_d.colour = cmd_colour;
               state_d      = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            if ((cmd_q.x1 > cmd_q.x2) || (cmd_q.y1 > cmd_q.y2)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               row_addr_d = cmd_q.base + row_off_s;
               row_d      = cmd_q.y1;
               first_d    = 1'b1;
               gen_done_d = 1'b0;
               state_d    = ROW;
            end
         end
         ROW: begin
            if (advance_s) begin
               out_valid_d   = 1'b1;
               out_address_d = word_addr_s;
               out_byte_en_d = mask_s;
               out_data_d    = replicate_colour(cmd_q.colour);
               if (is_last_s) begin
                  if (row_q == cmd_q.y2) begin
                     gen_done_d = 1'b1;
                  end else begin
                     row_addr_d = row_addr_q + stride_ext_s;
                     row_d      = row_q + {{(COORD_W-1){1'b0}}, 1'b1};
                     first_d    = 1'b1;
                  end
               end else begin
                  nxt_d   = word_addr_s + {{(ADDR_W-3){1'b0}}, 3'd4};
                  first_d = 1'b0;
               end
            end else if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               done_d      = 1'b1;
               state_d     = IDLE;
            end else begin
               state_d = ROW;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         cmd_q         <= '0;
         row_addr_q    <= '0;
         row_q         <= '0;
         nxt_q         <= '0;
         first_q       <= 1'b0;
         gen_done_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_address_q <= '0;
         out_byte_en_q <= 4'b0000;
         out_data_q    <= 32'h0000_0000;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         row_addr_q    <= row_addr_d;
         row_q         <= row_d;
         nxt_q         <= nxt_d;
         first_q       <= first_d;
         gen_done_q    <= gen_done_d;
         out_valid_q   <= out_valid_d;
         out_address_q <= out_address_d;
         out_byte_en_q <= out_byte_en_d;
         out_data_q    <= out_data_d;
         done_q        <= done_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign out_valid   = out_valid_q;
   assign out_address = out_address_q;
   assign out_byte_en = out_byte_en_q;
   assign out_data    = out_data_q;
   assign done        = done_q;

endmodule

// File: tb/tb_blitter_rect_fill.sv
// Randomised self-checking bench for blitter_rect_fill against a byte-range
// reference model of the rectangle fill.
module tb_blitter_rect_fill;

   localparam longint unsigned AMASK = (64'd1 << 26) - 64'd1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [25:0] cmd_base = 26'd0;
   logic [15:0] cmd_stride = 16'd0;
   logic [15:0] cmd_x1 = 16'd0;
   logic [15:0] cmd_y1 = 16'd0;
   logic [15:0] cmd_x2 = 16'd0;
   logic [15:0] cmd_y2 = 16'd0;
   logic [7:0]  cmd_colour = 8'd0;
   logic [25:0] out_address;
   logic [3:0]  out_byte_en;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        done;

   typedef struct {
      logic [25:0] addr;
      logic [3:0]  en;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   blitter_rect_fill dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_base    (cmd_base),
      .cmd_stride  (cmd_stride),
      .cmd_x1      (cmd_x1),
      .cmd_y1      (cmd_y1),
      .cmd_x2      (cmd_x2),
      .cmd_y2      (cmd_y2),
      .cmd_colour  (cmd_colour),
      .out_address (out_address),
      .out_byte_en (out_byte_en),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: every byte whose address lies in [s, e] (mod 2^26) of each row is written.
   task automatic build_expected(input logic [25:0] base, input logic [15:0] stride,
                                 input logic [15:0] x1, input logic [15:0] y1,
                                 input logic [15:0] x2, input logic [15:0] y2,
                                 input logic [7:0] col);
      longint unsigned row, s, e, w, off;
      wr_t item;
      exp_q.delete();
      if (x1 > x2 || y1 > y2) return;
      for (longint unsigned y = y1; y <= y2; y++) begin
         row = longint'(base) + y * longint'(stride);
         s   = (row + x1) & AMASK;
         e   = (row + x2) & AMASK;
         w   = s & ~64'd3;
         forever begin
            item.addr = w[25:0];
            item.data = {4{col}};
            for (int i = 0; i < 4; i++) begin
               off = (w + longint'(i) - s) & AMASK;
               item.en[i] = (off <= longint'(x2 - x1));
            end
            exp_q.push_back(item);
            if (w == (e & ~64'd3)) break;
            w = (w + 64'd4) & AMASK;
         end
      end
   endtask

   // mode 0: out_ready always high; mode 1: random. abort_after>0: reset after that many writes.
   task automatic run_cmd(input logic [25:0] base, input logic [15:0] stride,
                          input logic [15:0] x1, input logic [15:0] y1,
                          input logic [15:0] x2, input logic [15:0] y2,
                          input logic [7:0] col, input int mode, input int abort_after);
      int k, hs, first_valid_k, first_hs_k, last_hs_k, done_k, nexp;
      bit stalled, degenerate;
      logic [25:0] st_addr;
      logic [3:0]  st_en;
      logic [31:0] st_data;
      wr_t w;
      build_expected(base, stride, x1, y1, x2, y2, col);
      nexp = exp_q.size();
      degenerate = (x1 > x2) || (y1 > y2);
      cmd_valid = 1'b1; cmd_base = base; cmd_stride = stride;
      cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2; cmd_colour = col;
      check_val("cmd_ready_idle", cmd_ready, 1);
      @(posedge clock);
      @(negedge clock);
      k = 1; hs = 0; first_valid_k = -1; first_hs_k = -1; last_hs_k = -1; done_k = -1;
      stalled = 1'b0; st_addr = '0; st_en = '0; st_data = '0;
      while (done_k < 0 && k < 3000) begin
         cmd_valid  = busy && ($urandom_range(0, 1) == 1);
         cmd_base   = 26'($urandom); cmd_stride = 16'($urandom);
         cmd_x1     = 16'($urandom); cmd_x2     = 16'($urandom);
         cmd_y1     = 16'($urandom); cmd_y2     = 16'($urandom);
         cmd_colour = 8'($urandom);
         out_ready  = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
         if (stalled) begin
            check_val("stall_valid", out_valid, 1);
            check_val("stall_addr", out_address, st_addr);
            check_val("stall_en", out_byte_en, st_en);
            check_val("stall_data", out_data, st_data);
         end
         if (out_valid && first_valid_k < 0) first_valid_k = k;
         if (done) begin
            done_k = k;
            check_val("done_cmd_ready", cmd_ready, 1);
            check_val("done_busy", busy, 0);
         end
         if (out_valid && out_ready) begin
            check_val("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               check_val("wr_addr", out_address, w.addr);
               check_val("wr_en", out_byte_en, w.en);
               check_val("wr_data", out_data, w.data);
            end
            hs++;
            if (first_hs_k < 0) first_hs_k = k;
            last_hs_k = k;
            if (abort_after > 0 && hs == abort_after) begin
               reset = 1'b1; cmd_valid = 1'b0;
               @(posedge clock);
               @(negedge clock);
               check_val("rst_out_valid", out_valid, 0);
               check_val("rst_busy", busy, 0);
               check_val("rst_done", done, 0);
               reset = 1'b0;
               for (int i = 0; i < 6; i++) begin
                  @(negedge clock);
                  check_val("post_rst_valid", out_valid, 0);
                  check_val("post_rst_done", done, 0);
               end
               exp_q.delete();
               return;
            end
         end
         stalled = out_valid && !out_ready;
         st_addr = out_address; st_en = out_byte_en; st_data = out_data;
         @(negedge clock);
         k++;
      end
      cmd_valid = 1'b0;
      out_ready = 1'b1;
      check_val("done_seen", done_k >= 0, 1);
      if (degenerate) begin
         check_val("degen_done_k", done_k, 2);
         check_val("degen_writes", hs, 0);
      end else begin
         check_val("first_valid_k", first_valid_k, 3);
         check_val("write_count", hs, nexp);
         check_val("exp_left", exp_q.size(), 0);
         check_val("done_after_last", done_k, last_hs_k + 1);
         if (mode == 0) check_val("no_bubble", last_hs_k - first_hs_k, nexp - 1);
      end
      check_val("done_width", done, 0);
      check_val("idle_valid", out_valid, 0);
      exp_q.delete();
   endtask

   initial begin
      logic [25:0] rb;
      logic [15:0] rx1, ry1, rx2, ry2;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_val("rst_valid", out_valid, 0);
      check_val("rst_addr", out_address, 0);
      check_val("rst_en", out_byte_en, 0);
      check_val("rst_data", out_data, 0);
      check_val("rst_busy0", busy, 0);
      check_val("rst_done0", done, 0);
      reset = 1'b0;
      @(negedge clock);
      check_val("rst_cmd_ready", cmd_ready, 1);

      run_cmd(26'h0001000, 16'd320, 16'd5, 16'd2, 16'd5, 16'd2, 8'hAB, 0, 0);
      run_cmd(26'h0000000, 16'd64, 16'd1, 16'd0, 16'd9, 16'd0, 8'h5C, 0, 0);
      run_cmd(26'h0000000, 16'd16, 16'd0, 16'd0, 16'd7, 16'd2, 8'h33, 0, 0);
      run_cmd(26'h0000000, 16'd64, 16'd1, 16'd0, 16'd9, 16'd0, 8'hC4, 1, 0);
      run_cmd(26'h0000000, 16'd64, 16'd9, 16'd0, 16'd1, 16'd0, 8'h11, 0, 0);
      run_cmd(26'h3FFFFFE, 16'd64, 16'd0, 16'd0, 16'd3, 16'd0, 8'h7E, 0, 0);
      run_cmd(26'h0000000, 16'd16, 16'd0, 16'd0, 16'd7, 16'd2, 8'h44, 0, 3);
      run_cmd(26'h0000100, 16'd16, 16'd0, 16'd0, 16'd7, 16'd2, 8'h99, 0, 0);

      for (int t = 0; t < 25; t++) begin
         rb  = ($urandom_range(0, 3) == 0) ? 26'h3FFFFF0 + 26'($urandom_range(0, 15))
                                            : 26'($urandom);
         rx1 = 16'($urandom_range(0, 40));
         rx2 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 40))
                                            : rx1 + 16'($urandom_range(0, 30));
         ry1 = 16'($urandom_range(0, 2000));
         ry2 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 2000))
                                            : ry1 + 16'($urandom_range(0, 3));
         run_cmd(rb, 16'($urandom_range(0, 400)), rx1, ry1, rx2, ry2, 8'($urandom),
                 $urandom_range(0, 1), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/blitter_rect_fill.md
# blitter_rect_fill

Rectangle-fill engine for the blitter, sitting directly upstream of the blitter write FIFO. It accepts one fill command (base address, stride, inclusive corner coordinates, 8-bit colour) and walks the rectangle row by row. For each row it emits word-aligned 32-bit writes with per-byte enables on a valid/ready stream that connects straight to the FIFO write port. Pixels are 8-bit indexed, one byte per pixel.

## Interface
Parameters:
- ADDR_W, 26, byte-address width; matches the FIFO address field.
- COORD_W, 16, coordinate and stride width.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_base  in  ADDR_W  byte address of pixel (0,0).
- cmd_stride  in  COORD_W  bytes per row.
- cmd_x1, cmd_y1, cmd_x2, cmd_y2  in  COORD_W each  inclusive, unsigned corners.
- cmd_colour  in  8  fill colour.
- out_address  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0. Drives FIFO wr_address.
- out_byte_en  out  4  bit i enables byte address out_address+i.
- out_data  out  32  cmd_colour replicated into all four bytes.
- out_valid  out  1  write present.
- out_ready  in  1  FIFO wr_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final write is accepted.

## Operation
- States: IDLE, SETUP, ROW.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the command and go to SETUP.
- SETUP (1 cycle):
  - If x1>x2 or y1>y2, pulse done on the next cycle and return to IDLE with no writes.
  - Otherwise compute row_addr = base + y1*stride, mod 2^ADDR_W (one registered multiply).
  - Set the row counter to y1 and go to ROW.
- ROW:
  - For the current row, start byte s = row_addr+x1 and end byte e = row_addr+x2, both mod 2^ADDR_W.
  - Words run from cur = s&~3 to last = e&~3, advancing cur by 4 on each handshake.
  - Byte-enable mask:
    - first-word mask = 4'b1111 << s[1:0];
    - last-word mask = 4'b1111 >> (3-e[1:0]);
    - a word that is both first and last (cur==last, equality compare, so address wrap is harmless) uses the AND of the two masks;
    - middle words use 4'b1111.
  - Handshake: a write transfers when out_valid && out_ready. While out_valid=1 and out_ready=0, address, byte_en and data stay stable.
  - After the last word of a row:
    - if row==y2, clear out_valid, pulse done and go to IDLE;
    - otherwise row_addr += stride, row += 1, and the next row's first word is presented in the next cycle with no bubble.
- All address arithmetic is modulo 2^ADDR_W. The y1*stride product is truncated to ADDR_W bits.
- Reset at any time, including mid-rectangle:
  - state goes to IDLE and the current command is abandoned;
  - no further writes are issued and no done pulse is generated.

## Timing
- Reset values: out_valid=0, out_address=0, out_byte_en=0, out_data=0, busy=0, done=0. cmd_ready=1 from the first cycle after reset.
- Latency: command accepted at edge N; first out_valid=1 in the cycle after edge N+2 (one SETUP cycle, then ROW).
- Throughput: one word per cycle while out_ready=1, including across row boundaries.
- done is high for exactly one cycle, the cycle after the final handshake (or after SETUP for a degenerate command). cmd_ready is high in that same cycle.
- cmd_valid is ignored while busy. The latched command is unaffected by cmd_* changes after acceptance.
- out_ready low for any number of cycles only stalls; no write is lost or duplicated.

## Structure
- Shared package blitter_pkg holds:
  - ADDR_W and COORD_W;
  - the state enumeration (IDLE, SETUP, ROW);
  - a packed fill-command struct reused by the command decoder.
- Sub-module blitter_byte_mask: purely combinational. Inputs s[1:0], e[1:0], is_first, is_last; output the 4-bit enable. It is reused by a future copy engine.
- Everything else is a single sequential module.

## Test plan
- Single pixel: base=0x1000, stride=320, (5,2)-(5,2), colour 0xAB.
  - Exactly one write: address 0x1284, byte_en 4'b0010, data 0xABABABAB; then done.
- Multi-word row: base=0, stride=64, (1,0)-(9,0).
  - Writes: addr 0 en 1110, addr 4 en 1111, addr 8 en 0011.
  - All data = colour replicated; done one cycle after the last handshake.
- Multi-row, no bubble: stride=16, (0,0)-(7,2), out_ready=1 throughout.
  - Six writes on consecutive cycles: 0, 4, 16, 20, 32, 36, all en 1111.
- Backpressure: repeat the multi-word row case with out_ready toggling 0/1 randomly.
  - Same three writes in order; payload stable while stalled; no duplicates.
- Degenerate and wrap:
  - (9,0)-(1,0) gives zero writes and a done pulse 2 cycles after accept.
  - base=0x3FFFFFE, (0,0)-(3,0) gives writes at 0x3FFFFFC en 1100, then 0x0000000 en 0011.
- Reset mid-operation: assert reset during row 1 of the multi-row case.
  - Next cycle out_valid=0, busy=0, no done pulse.
  - A new command is then accepted and completes normally.
